// File: rtl/divider_mem_writeback.sv
// divider_mem_writeback
// Return path from the eight divider units to scratch memory. One group of
// eight 32-bit quotients is accepted through a valid/ready handshake, packed
// into two 128-bit words and written to consecutive scratch-memory addresses
// under memory backpressure. After NUM_GROUPS groups a sticky done flag is set.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   enable            gates acceptance of new groups only
//   div_valid/ready   group handshake (div_ready = idle && enable)
//   quot1..quot8      divider results, quot1 = lowest lane
//   sc_mem_wr_*       scratch-memory write request/ready/address/data
//   wb_busy           group captured, writes outstanding
//   wb_done           sticky: NUM_GROUPS groups written
//
// Optional feature: define DIVWB_CLAMP_EN to saturate every quotient to
// 8 bits (values above 0xFF stored as 0xFF) before capture.

module divider_mem_writeback #(
  parameter int          ADDR_W     = 8,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned NUM_GROUPS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              div_valid,
  output logic              div_ready,
  input  logic [31:0]       quot1,
  input  logic [31:0]       quot2,
  input  logic [31:0]       quot3,
  input  logic [31:0]       quot4,
  input  logic [31:0]       quot5,
  input  logic [31:0]       quot6,
  input  logic [31:0]       quot7,
  input  logic [31:0]       quot8,
  output logic              sc_mem_wr_en,
  input  logic              sc_mem_wr_rdy,
  output logic [ADDR_W-1:0] sc_mem_wr_addr,
  output logic [127:0]      sc_mem_wr_data,
  output logic              wb_busy,
  output logic              wb_done
);

  localparam int CNT_W = $clog2(NUM_GROUPS + 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LAST_GRP = CNT_W'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0][31:0]     quot_q, quot_d;
  logic [7:0][31:0]     quot_in_s;
  logic [7:0][31:0]     capture_s;
  logic                 wr_en_q, wr_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [127:0]         data_q, data_d;

  // Saturate one quotient to the 8-bit range.
  function automatic logic [31:0] clamp8(input logic [31:0] q);
    if (q > 32'h0000_00FF) begin
      return 32'h0000_00FF;
    end else begin
      return q;
    end
  endfunction

  assign quot_in_s = {quot8, quot7, quot6, quot5, quot4, quot3, quot2, quot1};

  // Value stored into the quotient registers on acceptance.
  always_comb begin
    capture_s = quot_in_s;
`ifdef DIVWB_CLAMP_EN
    for (int i = 0; i < 8; i++) begin
      capture_s[i] = clamp8(quot_in_s[i]);
    end
`else
    for (int i = 0; i < 8; i++) begin
      capture_s[i] = quot_in_s[i];
    end
`endif
  end

  // The only input-to-output path; held low while reset is asserted.
  assign div_ready = (state_q == IDLE) && enable && !reset;

  // Next-state, pointer, counter and capture logic plus next output values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    case (state_q)
      IDLE: begin
        if (div_valid && div_ready) begin
          quot_d  = capture_s;
          state_d = WR_LO;
        end else begin
          state_d = IDLE;
        end
      end
      WR_LO: begin
        if (sc_mem_wr_rdy) begin
          ptr_d   = ptr_q + ADDR_W'(1);
          state_d = WR_HI;
        end else begin
          state_d = WR_LO;
        end
      end
      WR_HI: begin
        if (sc_mem_wr_rdy) begin
          ptr_d   = ptr_q + ADDR_W'(1);
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_q == LAST_GRP) ? DONE : IDLE;
        end else begin
          state_d = WR_HI;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they track state_q.
    wr_en_d = (state_d == WR_LO) || (state_d == WR_HI);
    busy_d  = wr_en_d;
    done_d  = (state_d == DONE);
    case (state_d)
      WR_LO:   data_d = {quot_d[3], quot_d[2], quot_d[1], quot_d[0]};
      WR_HI:   data_d = {quot_d[7], quot_d[6], quot_d[5], quot_d[4]};
      default: data_d = 128'd0;
    endcase
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= BASE;
      cnt_q   <= '0;
      quot_q  <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 128'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  assign sc_mem_wr_en   = wr_en_q;
  assign sc_mem_wr_addr = ptr_q;
  assign sc_mem_wr_data = data_q;
  assign wb_busy        = busy_q;
  assign wb_done        = done_q;

endmodule
